// File: rtl/sig_misr_bank.sv
// sig_misr_bank: per-channel MISR signature bank over a window of DEPTH accepted beats.
// Clock is clock_0 (posedge); clock_1 is the asynchronous active-low reset.
// Optional feature: define SIG_MISR_FOLD_EN to add sig_fold, the XOR of all
// channel signatures, captured on entry to DONE.
module sig_misr_bank #(
   parameter int unsigned W       = 16,
   parameter int unsigned CH      = 4,
   parameter int unsigned DEPTH   = 64,
   parameter logic [W-1:0] RST_VAL = 16'h0239,
   parameter logic [W-1:0] POLY    = 16'h8016
) (
   input  logic                         clock_0,
   input  logic                         clock_1,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [CH*W-1:0]              in_data,
   input  logic [CH-1:0]                in_mask,
   output logic                         in_ready,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CH*W-1:0]              sig,
   output logic                         overflow
`ifdef SIG_MISR_FOLD_EN
   ,
   output logic [W-1:0]                 sig_fold
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CH*W-1:0]  sig_q, sig_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept_c;
   logic             last_beat_c;

   // One MISR step: shift, conditional polynomial feedback, fold in data.
   function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] d);
      logic [W-1:0] shifted;
      shifted   = {s[W-2:0], 1'b0};
      misr_step = shifted ^ (s[W-1] ? POLY : '0) ^ d;
   endfunction

   // Handshake decode; start always wins over a concurrent beat.
   always_comb begin
      accept_c    = in_valid && busy_q && !start;
      last_beat_c = (count_q == CNT_W'(DEPTH - 1));
   end

   // Run-control next state.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN:  if (accept_c && last_beat_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Signature, counter and overflow datapath.
   always_comb begin
      sig_d      = sig_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (start) begin
         sig_d      = {CH{RST_VAL}};
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (accept_c) begin
         for (int c = 0; c < CH; c++) begin
            if (in_mask[c]) begin
               sig_d[c*W +: W] = misr_step(sig_q[c*W +: W], in_data[c*W +: W]);
            end
         end
         count_d = count_q + CNT_W'(1);
      end else if (in_valid && !busy_q) begin
         overflow_d = 1'b1;
      end
   end

   // Status flags track the next state so they line up with the state register.
   always_comb begin
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clock_0 or negedge clock_1) begin
      if (!clock_1) begin
         state_q    <= ST_IDLE;
         sig_q      <= {CH{RST_VAL}};
         count_q    <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sig_q      <= sig_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef SIG_MISR_FOLD_EN
   logic [W-1:0] fold_q, fold_d;

   // Fold of the post-update signatures, captured on the DONE-entering edge.
   always_comb begin
      fold_d = fold_q;
      if (start) begin
         fold_d = '0;
      end else if (accept_c && last_beat_c) begin
         fold_d = '0;
         for (int c = 0; c < CH; c++) begin
            fold_d = fold_d ^ sig_d[c*W +: W];
         end
      end
   end

   // Fold register.
   always_ff @(posedge clock_0 or negedge clock_1) begin
      if (!clock_1) begin
         fold_q <= '0;
      end else begin
         fold_q <= fold_d;
      end
   end

   assign sig_fold = fold_q;
`endif

   assign in_ready = busy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign sig      = sig_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_sig_misr_bank.sv
// Randomised bench for sig_misr_bank against a window-level behavioural model.
module tb_sig_misr_bank;

   localparam int unsigned W     = 16;
   localparam int unsigned CH    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                start;
   logic                in_valid;
   logic [CH*W-1:0]     in_data;
   logic [CH-1:0]       in_mask;

   logic                in_ready, busy, done, overflow;
   logic [CNT_W-1:0]    count;
   logic [CH*W-1:0]     sig;

   logic                in_ready1, busy1, done1, overflow1;
   logic                count1;
   logic [CH*W-1:0]     sig1;
`ifdef SIG_MISR_FOLD_EN
   logic [W-1:0]        sig_fold, sig_fold1;
`endif

   sig_misr_bank #(.W(W), .CH(CH), .DEPTH(DEPTH), .RST_VAL(16'h0239), .POLY(16'h8016)) u_dut (
      .clock_0(clk), .clock_1(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_mask(in_mask), .in_ready(in_ready), .busy(busy),
      .done(done), .count(count), .sig(sig), .overflow(overflow)
`ifdef SIG_MISR_FOLD_EN
      , .sig_fold(sig_fold)
`endif
   );

   sig_misr_bank #(.W(W), .CH(CH), .DEPTH(1), .RST_VAL(16'h0239), .POLY(16'h8016)) u_dut1 (
      .clock_0(clk), .clock_1(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_mask(in_mask), .in_ready(in_ready1), .busy(busy1),
      .done(done1), .count(count1), .sig(sig1), .overflow(overflow1)
`ifdef SIG_MISR_FOLD_EN
      , .sig_fold(sig_fold1)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: window progress is "started" plus number of beats taken.
   int unsigned m_sig[CH];
   int          m_cnt;
   bit          m_started;
   bit          m_ovf;
   int unsigned m_fold;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned misr(input int unsigned s, input int unsigned d);
      int unsigned fb;
      fb = (s >= 32768) ? 32'h8016 : 32'h0;
      return ((s * 2) % 65536) ^ fb ^ d;
   endfunction

   function automatic logic [63:0] m_sigvec();
      logic [63:0] v;
      v = '0;
      for (int c = 0; c < CH; c++) v[c*W +: W] = W'(m_sig[c]);
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) m_sig[c] = 32'h0239;
      m_cnt = 0; m_started = 0; m_ovf = 0; m_fold = 0;
   endtask

   task automatic model_step(input bit st, input bit v, input logic [63:0] d, input logic [3:0] m);
      bit running;
      running = m_started && (m_cnt < DEPTH);
      if (st) begin
         for (int c = 0; c < CH; c++) m_sig[c] = 32'h0239;
         m_cnt = 0; m_started = 1; m_ovf = 0; m_fold = 0;
      end else if (v && running) begin
         for (int c = 0; c < CH; c++)
            if (m[c]) m_sig[c] = misr(m_sig[c], 32'(d[c*W +: W]));
         m_cnt++;
         if (m_cnt == DEPTH) begin
            m_fold = 0;
            for (int c = 0; c < CH; c++) m_fold = m_fold ^ m_sig[c];
         end
      end else if (v) begin
         m_ovf = 1;
      end
   endtask

   task automatic compare_all(input string tag);
      bit running, finished;
      running  = m_started && (m_cnt < DEPTH);
      finished = m_started && (m_cnt == DEPTH);
      chk({tag, "_sig"},      64'(sig),      m_sigvec());
      chk({tag, "_count"},    64'(count),    64'(m_cnt));
      chk({tag, "_busy"},     64'(busy),     64'(running));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(running));
      chk({tag, "_done"},     64'(done),     64'(finished));
      chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
`ifdef SIG_MISR_FOLD_EN
      chk({tag, "_fold"},     64'(sig_fold), 64'(m_fold));
`endif
   endtask

   // One clock: present inputs, step the model at the edge, check at the negedge.
   task automatic drive_cycle(input bit st, input bit v, input logic [63:0] d, input logic [3:0] m,
                              input string tag);
      start = st; in_valid = v; in_data = d; in_mask = m;
      @(posedge clk);
      model_step(st, v, d, m);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      compare_all(tag);
   endtask

   // Assert reset between edges, check before the next posedge, release at a negedge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all({tag, "_inrst"});
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compare_all({tag, "_rel"});
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   logic [63:0] saved;

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;
      @(negedge clk);
      compare_all("idle");

      // Single masked beat on channel 0.
      drive_cycle(1, 0, '0, 4'h0, "t1_start");
      drive_cycle(0, 1, 64'h0001, 4'b0001, "t1_beat");
      chk("t1_ch0", 64'(sig[15:0]), 64'h0473);
      chk("t1_ch123", 64'(sig[63:16]), 64'h0239_0239_0239);
      chk("t1_count", 64'(count), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);

      // Feedback path.
      drive_cycle(1, 0, '0, 4'h0, "t2_start");
      drive_cycle(0, 1, 64'h8000, 4'b0001, "t2_b0");
      chk("t2_ch0_a", 64'(sig[15:0]), 64'h8472);
      drive_cycle(0, 1, 64'h0000, 4'b0001, "t2_b1");
      chk("t2_ch0_b", 64'(sig[15:0]), 64'h88F2);

      // Full window then a beat in DONE.
      drive_cycle(1, 0, '0, 4'h0, "t3_start");
      for (int i = 0; i < 4; i++) drive_cycle(0, 1, rand64(), 4'($urandom()), "t3_beat");
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_ready", 64'(in_ready), 64'd0);
      chk("t3_count", 64'(count), 64'd4);
      saved = sig;
      drive_cycle(0, 1, rand64(), 4'hF, "t3_extra");
      chk("t3_sig_hold", 64'(sig), saved);
      chk("t3_ovf", 64'(overflow), 64'd1);

      // Restart mid-window with a colliding beat.
      drive_cycle(1, 0, '0, 4'h0, "t4_start");
      drive_cycle(0, 1, rand64(), 4'hF, "t4_b0");
      drive_cycle(0, 1, rand64(), 4'hF, "t4_b1");
      chk("t4_count2", 64'(count), 64'd2);
      drive_cycle(1, 1, rand64(), 4'hF, "t4_restart");
      chk("t4_count0", 64'(count), 64'd0);
      chk("t4_sig", 64'(sig), 64'h0239_0239_0239_0239);
      chk("t4_ovf", 64'(overflow), 64'd0);

      // Asynchronous reset mid-window.
      drive_cycle(0, 1, rand64(), 4'hF, "t5_b0");
      async_reset("t5");
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_sig", 64'(sig), 64'h0239_0239_0239_0239);

      // DEPTH=1 instance: one accept finishes the window.
      drive_cycle(1, 0, '0, 4'h0, "t6_start");
      drive_cycle(0, 1, 64'h0008_0004_0002_0001, 4'hF, "t6_beat");
      chk("t6_sig1", 64'(sig1), 64'h047A_0476_0470_0473);
      chk("t6_done1", 64'(done1), 64'd1);
      chk("t6_busy1", 64'(busy1), 64'd0);
      chk("t6_count1", 64'(count1), 64'd1);
`ifdef SIG_MISR_FOLD_EN
      chk("t6_fold1", 64'(sig_fold1), 64'h000F);
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(99) < 2) begin
            async_reset("rnd_rst");
         end else begin
            drive_cycle($urandom_range(99) < 8, $urandom_range(99) < 65, rand64(),
                        4'($urandom()), "rnd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sig_misr_bank.md
Name: sig_misr_bank

Overview:
Parametrised multi-channel signature register bank for the equivalence-check harness.
- Compresses CH parallel W-bit output channels of a generated design under test into per-channel MISR signatures over a bounded window of DEPTH accepted beats.
- Compares simulator runs with one word per channel instead of full traces.
- Successor to the fixed-width, fixed-reset-constant register groups: width, channel count, window depth, polynomial and reset seed are all parameters; adds a valid/ready handshake and a run-control FSM.

Parameters:
W, 16, signature and data width per channel (>=2)
CH, 4, number of channels
DEPTH, 64, accepted beats per signature window (>=1)
RST_VAL, 16'h0239, seed loaded into every signature on reset and on start
POLY, 16'h8016, MISR feedback polynomial (W bits)

Ports:
clock_0  in  1  clock; all state updates on posedge
clock_1  in  1  reset; asynchronous, active-low
start  in  1  begin/restart a window
in_valid  in  1  beat offered
in_data  in  CH*W  channel c at bits [c*W +: W]
in_mask  in  CH  1 = channel c folds this beat; 0 = channel c holds
in_ready  out  1  high only in RUN
busy  out  1  high in RUN
done  out  1  high in DONE
count  out  $clog2(DEPTH+1)  beats accepted in current window
sig  out  CH*W  channel signatures, registered
overflow  out  1  sticky: in_valid seen while not RUN

Behaviour:
- Reset (clock_1 low, async): state=IDLE, every sig channel=RST_VAL, count=0, overflow=0. All outputs derive from registers, so in_ready=busy=done=0.
- States:
  - IDLE: start -> RUN.
  - RUN: accepted beat with count==DEPTH-1 -> DONE.
  - DONE: start -> RUN.
  - DONE holds indefinitely otherwise.
- Entering RUN via start (from any state, RUN included):
  - every sig channel reloads RST_VAL; count=0; overflow=0.
  - A beat presented in the start cycle is discarded (start has priority).
- Accept = in_valid && in_ready && !start.
- On accept, for each channel c with in_mask[c]=1:
  - sig_c <= (sig_c<<1 truncated to W) ^ (sig_c[W-1] ? POLY : 0) ^ data_c.
  - Channels with in_mask[c]=0 hold.
  - count increments on every accept, including when in_mask is all zero.
- Latency: sig and count reflect a beat in the cycle after acceptance. done rises the cycle after the DEPTH-th accept.
- After reaching DEPTH in DONE, count stays at DEPTH; no wrap.
- in_valid=1 in IDLE or DONE: beat ignored, overflow<=1 (sticky until next start or reset).
- Reset asserted mid-window aborts immediately to the reset values; there is no partial signature retention.
- DEPTH=1: a single accept moves RUN->DONE.
- All arithmetic is unsigned, truncated to W bits; no sign extension anywhere.

Optional Feature:
Macro SIG_MISR_FOLD_EN.
- Defined: adds output port sig_fold (W bits, registered), the XOR of all CH post-update signatures.
  - Loaded on the clock edge that enters DONE.
  - Reset and start set it to 0.
  - Holds otherwise.
- Undefined: port sig_fold and its register are absent; all other behaviour is identical.

Test Plan:
1. Reset release, start=1 for one cycle, then in_valid=1, mask=4'b0001, ch0 data=16'h0001 -> next cycle sig ch0=16'h0473, ch1..3=16'h0239, count=1, busy=1.
2. From fresh start: ch0 data 16'h8000 then 16'h0000 (mask 4'b0001) -> ch0=16'h8472 then 16'h88F2 (feedback path).
3. DEPTH=4: four accepts with in_valid held high -> done=1 the cycle after the 4th, in_ready=0, count=4. A 5th in_valid leaves sig unchanged and sets overflow=1.
4. start asserted with in_valid=1 mid-window (count=2) -> count=0, all sig=16'h0239, beat not folded, overflow cleared.
5. Drop clock_1 asynchronously mid-window (between edges) -> outputs at reset values before the next posedge clock_0; state IDLE after release.
6. SIG_MISR_FOLD_EN, DEPTH=1, CH=4, all masks set, data ch0..3 = 16'h0001/0002/0004/0008 -> sig = 16'h0473/0470/0476/047A, sig_fold=16'h000F, done=1.
